// File: rtl/i2c_bus_monitor_pkg.sv
// Shared I2C monitor definitions: parameter defaults
// and bus FSM state encodings.
package i2c_bus_monitor_pkg;

    localparam int unsigned FILTER_LEN_DEF      = 4;
    localparam int unsigned BUS_FREE_CYCLES_DEF = 100;

    typedef enum logic [1:0] {
        ST_FREE      = 2'd0,
        ST_BUSY      = 2'd1,
        ST_WAIT_FREE = 2'd2
    } bus_state_e;

endpackage

// File: rtl/i2c_line_filter.sv
// One I2C line: 2-flop synchronizer, stability filter
// and edge detect on the filtered level.
module i2c_line_filter
    import i2c_bus_monitor_pkg::*;
#(
    parameter int unsigned FILTER_LEN = FILTER_LEN_DEF
) (
    input  logic i_clk,
    input  logic i_rst,
    input  logic i_line,
    output logic o_filt,
    output logic o_prev,
    output logic o_rise,
    output logic o_fall
);

    localparam int unsigned CW = $clog2(FILTER_LEN + 1);
    localparam logic [CW-1:0] LAST = CW'(FILTER_LEN - 1);

    logic          r_meta;
    logic          r_sync;
    logic [CW-1:0] r_cnt;
    logic          r_filt;
    logic          r_prev;

    // Bring the asynchronous pin into the clock domain.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_meta <= 1'b1;
            r_sync <= 1'b1;
        end else begin
            r_meta <= i_line;
            r_sync <= r_meta;
        end
    end

    // Accept a new level only after FILTER_LEN stable mismatches.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_cnt  <= '0;
            r_filt <= 1'b1;
        end else if (r_sync == r_filt) begin
            r_cnt  <= '0;
        end else if (r_cnt == LAST) begin
            r_cnt  <= '0;
            r_filt <= r_sync;
        end else begin
            r_cnt  <= r_cnt + 1'b1;
        end
    end

    // Delayed copy of the filtered level for edge detection.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_prev <= 1'b1;
        end else begin
            r_prev <= r_filt;
        end
    end

    assign o_filt = r_filt;
    assign o_prev = r_prev;
    assign o_rise = r_filt & ~r_prev;
    assign o_fall = ~r_filt & r_prev;

endmodule

// File: rtl/i2c_bus_monitor.sv
// Passive I2C bus monitor: filtered lines, edges,
// START/STOP detection and bus ownership FSM.
module i2c_bus_monitor
    import i2c_bus_monitor_pkg::*;
#(
    parameter int unsigned FILTER_LEN      = FILTER_LEN_DEF,
    parameter int unsigned BUS_FREE_CYCLES = BUS_FREE_CYCLES_DEF
) (
    input  logic clk,
    input  logic rst,
    input  logic scl_in,
    input  logic sda_in,
    output logic scl_filt,
    output logic sda_filt,
    output logic scl_rise,
    output logic scl_fall,
    output logic sda_rise,
    output logic sda_fall,
    output logic start_det,
    output logic stop_det,
    output logic bus_busy,
    output logic bus_free
);

    localparam int unsigned ICW = $clog2(BUS_FREE_CYCLES + 1);
    localparam logic [ICW-1:0] IDLE_LAST = ICW'(BUS_FREE_CYCLES - 1);

    logic           w_scl_prev;
    logic           w_sda_prev;
    logic           w_both_high;
    bus_state_e     r_state;
    bus_state_e     w_state_nxt;
    logic [ICW-1:0] r_idle;
    logic [ICW-1:0] w_idle_nxt;

    i2c_line_filter #(
        .FILTER_LEN (FILTER_LEN)
    ) u_scl (
        .i_clk  (clk),
        .i_rst  (rst),
        .i_line (scl_in),
        .o_filt (scl_filt),
        .o_prev (w_scl_prev),
        .o_rise (scl_rise),
        .o_fall (scl_fall)
    );

    i2c_line_filter #(
        .FILTER_LEN (FILTER_LEN)
    ) u_sda (
        .i_clk  (clk),
        .i_rst  (rst),
        .i_line (sda_in),
        .o_filt (sda_filt),
        .o_prev (w_sda_prev),
        .o_rise (sda_rise),
        .o_fall (sda_fall)
    );

    // SCL must be high on both sides of the SDA edge, so a
    // simultaneous SCL edge suppresses START/STOP.
    assign start_det   = sda_fall & scl_filt & w_scl_prev;
    assign stop_det    = sda_rise & scl_filt & w_scl_prev;
    assign w_both_high = scl_filt & sda_filt;

    // Next state and idle count; count is zero unless it
    // keeps accumulating inside WAIT_FREE.
    always_comb begin
        w_state_nxt = r_state;
        w_idle_nxt  = '0;
        unique case (r_state)
            ST_FREE: begin
                if (start_det) begin
                    w_state_nxt = ST_BUSY;
                end else if (!w_both_high) begin
                    w_state_nxt = ST_WAIT_FREE;
                end
            end
            ST_BUSY: begin
                if (stop_det) begin
                    w_state_nxt = ST_WAIT_FREE;
                end
            end
            ST_WAIT_FREE: begin
                if (start_det) begin
                    w_state_nxt = ST_BUSY;
                end else if (w_both_high) begin
                    if (r_idle == IDLE_LAST) begin
                        w_state_nxt = ST_FREE;
                    end else begin
                        w_idle_nxt = r_idle + 1'b1;
                    end
                end
            end
            default: begin
                w_state_nxt = ST_WAIT_FREE;
            end
        endcase
    end

    // State and idle counter registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= ST_WAIT_FREE;
            r_idle  <= '0;
        end else begin
            r_state <= w_state_nxt;
            r_idle  <= w_idle_nxt;
        end
    end

    assign bus_busy = (r_state == ST_BUSY);
    assign bus_free = (r_state == ST_FREE);

endmodule
